// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: frame capture and checking, make/break/E0 decode, an event FIFO
// and a held-key bitmap for a programmable set of keys.
module ps2_key_event_rx #(
  parameter int unsigned           CLK_DIV       = 250,
  parameter int unsigned           TIMEOUT_TICKS = 4000,
  parameter int unsigned           FIFO_DEPTH    = 8,
  parameter int unsigned           NUM_KEYS      = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES     = {9'h174, 9'h16B, 9'h023, 9'h01C}
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic                PS2_CLK,
  input  logic                PS2_DATA,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [7:0]          evt_code,
  output logic                evt_ext,
  output logic                evt_break,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                frame_err,
  output logic                overflow
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned ToW  = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);

  // Encoding chosen so bit0 = extended, bit1 = break.
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExt    = 2'd1;
  localparam logic [1:0] StBrk    = 2'd2;
  localparam logic [1:0] StExtBrk = 2'd3;

  // Input synchronisers
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_DATA;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Sample tick
  logic [DivW-1:0] div_q;
  logic            tick;

  assign tick = (div_q == DivW'(CLK_DIV - 1));

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) div_q <= '0;
    else             div_q <= tick ? '0 : div_q + 1'b1;
  end

  // Frame receiver
  logic            prev_clk_q;
  logic [10:0]     shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]      byte_q, byte_d;
  logic            byte_stb_q, byte_stb_d;
  logic            frame_err_q, frame_err_d;
  logic            fall;

  assign fall = tick & prev_clk_q & ~clk_s2_q;

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    byte_d      = byte_q;
    byte_stb_d  = 1'b0;
    frame_err_d = 1'b0;
    if (fall) begin
      shift_d  = {dat_s2_q, shift_q[10:1]};
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        // Start low, stop high, odd parity across data and parity bits.
        if (!shift_d[0] && shift_d[10] && (^shift_d[9:1])) begin
          byte_stb_d = 1'b1;
          byte_d     = shift_d[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (tick && (bit_cnt_q != 4'd0)) begin
      if (to_cnt_q == ToW'(TIMEOUT_TICKS - 1)) begin
        bit_cnt_d   = 4'd0;
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      prev_clk_q  <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      byte_q      <= '0;
      byte_stb_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (tick) prev_clk_q <= clk_s2_q;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      byte_q      <= byte_d;
      byte_stb_q  <= byte_stb_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Prefix decoder; evt layout is {ext, brk, code}
  logic [1:0] st_q, st_d;
  logic       push_q, push_d;
  logic [9:0] evt_q, evt_d;

  always_comb begin
    st_d   = st_q;
    push_d = 1'b0;
    evt_d  = evt_q;
    if (frame_err_q) begin
      st_d = StIdle;
    end else if (byte_stb_q) begin
      case (byte_q)
        8'hE0:        st_d = st_q | StExt;
        8'hF0:        st_d = st_q | StBrk;
        8'h00, 8'hFF: st_d = StIdle;
        default: begin
          push_d = 1'b1;
          evt_d  = {st_q[0], st_q[1], byte_q};
          st_d   = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      st_q   <= StIdle;
      push_q <= 1'b0;
      evt_q  <= '0;
    end else begin
      st_q   <= st_d;
      push_q <= push_d;
      evt_q  <= evt_d;
    end
  end

  // Held-key bitmap, updated alongside the push regardless of FIFO space
  logic [NUM_KEYS-1:0] held_q, held_d;

  always_comb begin
    held_d = held_q;
    if (push_q) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if ({evt_q[9], evt_q[7:0]} == KEY_CODES[9*i +: 9]) held_d[i] = ~evt_q[8];
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) held_q <= '0;
    else             held_q <= held_d;
  end

  // First-word fall-through event FIFO
  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, pop, wr_en;
  logic        overflow_q;
  logic [9:0]  head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = ~empty & evt_ready;
  assign wr_en = push_q & (~full | pop);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge CLK100MHZ) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= evt_q;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_q && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Head fields are masked so every output reads 0 while the FIFO is empty.
  assign evt_valid = ~empty;
  assign evt_code  = evt_valid ? head[7:0] : 8'h00;
  assign evt_break = evt_valid & head[8];
  assign evt_ext   = evt_valid & head[9];
  assign key_held  = held_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed plus randomized bench for ps2_key_event_rx with a byte-level reference model.
module tb_ps2_key_event_rx;

  localparam int CLK_DIV = 4;
  localparam int TO_TICKS = 4000;
  localparam int DEPTH = 8;
  localparam int HALF = 16;  // CLK100MHZ cycles per PS/2 clock half-period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_ext, evt_break, frame_err, overflow;
  logic [7:0] evt_code;
  logic [3:0] key_held;

  always #5 clk = ~clk;

  ps2_key_event_rx #(
    .CLK_DIV       (CLK_DIV),
    .TIMEOUT_TICKS (TO_TICKS),
    .FIFO_DEPTH    (DEPTH),
    .NUM_KEYS      (4),
    .KEY_CODES     ({9'h174, 9'h16B, 9'h023, 9'h01C})
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .PS2_CLK    (ps2_clk),
    .PS2_DATA   (ps2_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_break  (evt_break),
    .key_held   (key_held),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  int checks = 0;
  int passed = 0;
  int fails = 0;
  int err_cnt = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic [3:0] held_m = '0;
  logic       ovf_m = 1'b0;
  bit         ext_f = 0;
  bit         brk_f = 0;

  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (evt_valid && evt_ready) got_q.push_back({evt_ext, evt_break, evt_code});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  function automatic int key_index(input logic [8:0] k);
    case (k)
      9'h01C:  return 0;
      9'h023:  return 1;
      9'h16B:  return 2;
      9'h174:  return 3;
      default: return -1;
    endcase
  endfunction

  task automatic ps2_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Reference: prefixes accumulate as flags, any other non-error byte becomes an event.
  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) ext_f = 1;
    else if (b == 8'hF0) brk_f = 1;
    else if (b == 8'h00 || b == 8'hFF) begin
      ext_f = 0;
      brk_f = 0;
    end else begin
      k = key_index({ext_f, b});
      if (k >= 0) held_m[k] = ~brk_f;
      if (exp_q.size() - got_q.size() >= DEPTH) ovf_m = 1'b1;
      else exp_q.push_back({ext_f, brk_f, b});
      ext_f = 0;
      brk_f = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    ps2_bits(mk_frame(b, 1'b0), 11);
    wait_cyc(HALF);
  endtask

  task automatic check_stream(input string tag);
    wait_cyc(20);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_evt"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] b;
    do b = 8'($urandom_range(1, 254)); while (b == 8'hE0 || b == 8'hF0);
    return b;
  endfunction

  initial begin
    int err0;
    int r;
    logic [7:0] b;

    // Reset state
    wait_cyc(4);
    check("rst_valid", evt_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_code", evt_code, 0);
    rst_n = 1'b1;
    wait_cyc(10);

    // Single make with backpressure, then its break
    send_byte(8'h1C);
    check("mk_valid", evt_valid, 1);
    check("mk_head", {evt_ext, evt_break, evt_code}, exp_q[0]);
    check("mk_held", key_held, held_m);
    check("mk_held_a", key_held, 4'b0001);
    evt_ready = 1'b1;
    send_byte(8'hF0);
    check("held_after_prefix", key_held, 4'b0001);
    send_byte(8'h1C);
    check("brk_held", key_held, held_m);
    check_stream("make_break");

    // Extended make/break of Right
    send_byte(8'hE0);
    send_byte(8'h74);
    check("ext_mk_held", key_held, held_m);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    check("ext_brk_held", key_held, held_m);
    check_stream("ext");

    // Bad parity
    err0 = err_cnt;
    ps2_bits(mk_frame(8'h23, 1'b1), 11);
    wait_cyc(HALF);
    check("par_err_pulses", err_cnt - err0, 1);
    check("par_no_event", got_q.size(), 0);
    check("par_held", key_held, held_m);
    send_byte(8'h23);
    check("par_good_held", key_held, held_m);
    check_stream("parity");

    // Timeout after 5 bits
    err0 = err_cnt;
    ps2_bits(mk_frame(8'h55, 1'b0), 5);
    wait_cyc(TO_TICKS * CLK_DIV + 100);
    check("to_err_pulses", err_cnt - err0, 1);
    check("to_no_event", got_q.size(), 0);
    ext_f = 0;
    brk_f = 0;
    send_byte(8'h1B);
    check_stream("timeout");

    // Overflow: 9 makes with no consumer
    evt_ready = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < DEPTH + 1; i++) send_byte(rand_code());
    check("ovf_valid", evt_valid, 1);
    check("ovf_head", {evt_ext, evt_break, evt_code}, exp_q[0]);
    check("ovf_flag", overflow, ovf_m);
    check("ovf_held", key_held, held_m);
    wait_cyc(7);
    check("ovf_head_stable", {evt_ext, evt_break, evt_code}, exp_q[0]);
    evt_ready = 1'b1;
    check_stream("overflow");
    check("ovf_drained", evt_valid, 0);

    // Randomized byte stream
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'h1C;
        5:       b = 8'h23;
        6:       b = 8'h6B;
        7:       b = 8'h74;
        8:       b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
        default: b = rand_code();
      endcase
      send_byte(b);
      check("rnd_held", key_held, held_m);
    end
    check_stream("random");
    check("rnd_ovf", overflow, ovf_m);

    // Reset mid-frame with A and D held
    send_byte(8'h00);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    send_byte(8'h1C);
    send_byte(8'h23);
    check("pre_rst_held", key_held, 4'b0011);
    check_stream("pre_rst");
    ps2_bits(mk_frame(8'h1C, 1'b0), 4);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_held", key_held, 0);
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_ferr", frame_err, 0);
    held_m = '0;
    ovf_m = 1'b0;
    ext_f = 0;
    brk_f = 0;
    got_q.delete();
    exp_q.delete();
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(10);
    send_byte(8'h1C);
    check("post_rst_held", key_held, held_m);
    check_stream("post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_rx.md
Name: ps2_key_event_rx

Overview:
- Parametrised PS/2 keyboard receiver for the game-control path.
- Deserialises PS/2 frames and checks them (start, stop, odd parity, timeout), then decodes make, break and extended (E0) prefixes into key events.
- Events are buffered in a FIFO with a valid/ready handshake, so the game logic can consume every press and release.
- Also maintains a live "held" bitmap for a programmable set of keys, replacing ad-hoc per-key direction decoding.

Parameters:
- CLK_DIV, 250: CLK100MHZ cycles per PS/2 sample tick (400 kHz at default); must be >= 2.
- TIMEOUT_TICKS, 4000: sample ticks without a falling PS2_CLK edge before an in-progress frame is aborted.
- FIFO_DEPTH, 8: event FIFO entries; must be a power of 2 and >= 2.
- NUM_KEYS, 4: number of tracked keys in key_held.
- KEY_CODES, {9'h174, 9'h16B, 9'h023, 9'h01C}: NUM_KEYS packed 9-bit entries {ext, code}. Entry i sits at bits [9i+8:9i]. Default order is bit0=A, bit1=D, bit2=Left, bit3=Right.

Ports:
- CLK100MHZ  in  1  board clock.
- CPU_RESETN  in  1  asynchronous active-low reset.
- PS2_CLK  in  1  keyboard clock; asynchronous.
- PS2_DATA  in  1  keyboard data; asynchronous.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event.
- evt_code  out  8  head event scan code.
- evt_ext  out  1  head event had the E0 prefix.
- evt_break  out  1  head event is a release (F0 prefix).
- key_held  out  NUM_KEYS  bit i = 1 while KEY_CODES[i] is held.
- frame_err  out  1  one-cycle pulse on a bad frame or timeout.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.

Behaviour:
- Reset (CPU_RESETN=0, asynchronous):
  - All outputs 0; FIFO empty.
  - Decoder state IDLE; bit counter 0; tick divider 0.
  - Synchroniser flops for PS2_CLK and PS2_DATA reset to 1.
  - Reset mid-frame discards the partial frame.
- Input conditioning: PS2_CLK and PS2_DATA each pass through a 2-flop synchroniser.
- Tick: a 1-cycle enable, asserted once every CLK_DIV cycles. All receiver logic advances only on tick cycles.
- Receiver, bit capture:
  - A falling edge is a sampled clock of 0 where the previous tick's sample was 1.
  - On each falling edge, shift the data bit in LSB-first and increment the bit counter.
- Receiver, frame completion:
  - The frame completes on the tick where the bit counter reaches 11.
  - The frame is valid iff start=0, stop=1 and the parity over data+parity bits is odd.
  - Valid frame: raise a 1-cycle byte strobe on the next CLK100MHZ cycle.
  - Invalid frame: pulse frame_err on the next cycle and force the decoder to IDLE.
  - In both cases the bit counter returns to 0.
- Timeout:
  - While the bit counter is between 1 and 10, count ticks since the last falling edge.
  - When the count reaches TIMEOUT_TICKS: bit counter to 0, pulse frame_err, decoder to IDLE.
- Decoder FSM (states IDLE, EXT, BRK, EXTBRK), acting on byte strobe:
  - Byte 0xE0: IDLE->EXT, BRK->EXTBRK.
  - Byte 0xF0: IDLE->BRK, EXT->EXTBRK.
  - Bytes 0x00 and 0xFF (keyboard error codes): ignored, state returns to IDLE.
  - Any other byte: emit event {ext = state in EXT/EXTBRK, brk = state in BRK/EXTBRK, code = byte}, state to IDLE.
  - A repeated prefix (e.g. E0 in EXT) keeps the current state.
- Event emit:
  - Pushes the event to the FIFO in the cycle after the byte strobe.
  - Updates key_held in the same cycle: for each i with {ext, code} == KEY_CODES[i], set bit i on make, clear it on break.
  - key_held updates even when the FIFO is full.
  - A break for a key not held leaves the bit at 0. Typematic repeat makes re-push events but leave the bit at 1.
- FIFO (first-word fall-through):
  - evt_valid = not empty; evt_code, evt_ext and evt_break show the head entry.
  - Pop when evt_valid && evt_ready.
  - Latency: an event pushed into an empty FIFO is visible the cycle after the push, i.e. 2 cycles after the byte strobe.
  - Outputs hold stable while evt_valid=1 and evt_ready=0.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Push while full with no pop: the new event is dropped and overflow is set; overflow clears only on reset.
  - Push and pop in the same cycle while full: both happen, no drop.
  - Push and pop in the same cycle while empty: the push lands and the FIFO is non-empty the next cycle.

Test Plan:
- Send valid frame 0x1C, evt_ready=0 -> evt_valid=1, evt_code=0x1C, ext=0, break=0; key_held=4'b0001 and stays until the break.
- Send E0 74 then E0 F0 74 -> two events {1,0,0x74} then {1,1,0x74}; key_held[3] rises after the first event and falls after the second; no event is produced for the prefixes.
- Frame 0x23 with the parity bit flipped -> frame_err pulses once; no event; key_held unchanged; a following good 0x23 produces an event normally.
- Stop clocking after 5 bits for 4000 ticks -> frame_err pulses; a following full 0x1B frame decodes to evt_code=0x1B.
- Hold evt_ready=0 and send 9 make codes with FIFO_DEPTH=8 -> the first 8 are stored in order, the 9th is dropped, overflow=1; with evt_ready=1, 8 pops in the original order, then evt_valid=0.
- Assert CPU_RESETN=0 mid-frame with key_held=4'b0011 -> all outputs 0 immediately; after release, the next full frame decodes correctly.
